piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 77 +++++++
 tb/tb_piso_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, MSB first, ready/valid load side.
// Define PISO_TX_PARITY_EN to append an even-parity bit after each word.
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0] cnt;
  logic last;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
`ifdef PISO_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (load_valid && load_ready) begin
        sreg <= load_data;
        cnt  <= '0;
`ifdef PISO_TX_PARITY_EN
        par  <= 1'b0;
`endif
      end else if (state == SHIFT) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        cnt  <= cnt + CW'(1);
`ifdef PISO_TX_PARITY_EN
        par  <= par ^ sreg[WIDTH-1];
`endif
      end
    end
  end
  always_comb begin
    state_nxt  = state;
    load_ready = state == IDLE;
    busy       = state != IDLE;
    done       = state == DONE;
`ifdef PISO_TX_PARITY_EN
    ser_valid  = state == SHIFT || state == PARITY;
    ser_out    = state == SHIFT ? sreg[WIDTH-1] : state == PARITY ? par : 1'b0;
`else
    ser_valid  = state == SHIFT;
    ser_out    = state == SHIFT ? sreg[WIDTH-1] : 1'b0;
`endif
    case (state)
      IDLE:    state_nxt = load_valid ? SHIFT : IDLE;
`ifdef PISO_TX_PARITY_EN
      SHIFT:   state_nxt = last ? PARITY : SHIFT;
      PARITY:  state_nxt = DONE;
`else
      SHIFT:   state_nxt = last ? DONE : SHIFT;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed self-checking bench for piso_tx at WIDTH=8.
module tb_piso_tx;
  localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic load_ready, ser_out, ser_valid, busy, done;
  int n_cmp = 0;
  int n_bad = 0;

  piso_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_bit(input logic [W-1:0] w, input int i);
    return i < W ? w[W-1-i] : ^w;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, load_ready, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, ser_valid, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_out"}, ser_out, 1'b0);
  endtask

  // Accept w in the current cycle, then follow it through every serial bit, DONE and back to IDLE.
  task automatic send_word(input logic [W-1:0] w, input bit disturb);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (disturb && i == 2) begin
        load_data  = 8'hFF;
        load_valid = 1'b1;
      end
      check("word_valid", ser_valid, 1'b1);
      check("word_bit", ser_out, exp_bit(w, i));
      check("word_busy", busy, 1'b1);
      check("word_notready", load_ready, 1'b0);
      check("word_nodone", done, 1'b0);
      tick();
    end
    load_valid = 1'b0;
    check("done_pulse", done, 1'b1);
    check("done_valid", ser_valid, 1'b0);
    check("done_out", ser_out, 1'b0);
    check("done_busy", busy, 1'b1);
    check("done_ready", load_ready, 1'b0);
    tick();
    check_idle("after_done");
  endtask

  initial begin
    logic ev, eo, ed;
    int k;
    tick();
    tick();
    reset = 1'b1;
    check_idle("reset");

    send_word(8'hB5, 1'b0);
    send_word(8'h00, 1'b0);
    send_word(8'hB5, 1'b1);
    send_word(8'h6E, 1'b0);

    // load_valid held high across two words: the second accept lands on the IDLE cycle after DONE.
    load_valid = 1'b1;
    load_data  = 8'h01;
    tick();
    load_data  = 8'h80;
    for (k = 0; k < 2 * NB + 3; k++) begin
      ev = (k < NB) || (k >= NB + 2 && k < 2 * NB + 2);
      eo = k < NB ? exp_bit(8'h01, k) : ev ? exp_bit(8'h80, k - NB - 2) : 1'b0;
      ed = k == NB || k == 2 * NB + 2;
      check("b2b_valid", ser_valid, ev);
      check("b2b_bit", ser_out, eo);
      check("b2b_done", done, ed);
      check("b2b_ready", load_ready, k == NB + 1);
      if (k == 2 * NB + 2) load_valid = 1'b0;
      tick();
    end
    check_idle("b2b_end");
    tick();
    check_idle("b2b_nodup");

    // Reset mid-word aborts it without a done pulse.
    load_valid = 1'b1;
    load_data  = 8'hB5;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle("abort");
    send_word(8'h3C, 1'b0);

    // Reset wins over a simultaneous handshake.
    reset      = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    tick();
    reset      = 1'b1;
    load_valid = 1'b0;
    check_idle("rst_prio");
    tick();
    check_idle("rst_prio2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
